// File: rtl/fft_butterfly_stream.sv
// Streaming radix-2 DIT butterfly, 3-stage pipeline with a global valid/ready stall.
// Optional macro FFT_BFLY_SCALE_EN: S3 halves its results with round half-up instead of saturating.
module fft_butterfly_stream #(
    parameter int SAMPLE_W = 16,
    parameter int TW_W     = 16,
    parameter int TAG_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] even_re,
    input  logic [SAMPLE_W-1:0] even_im,
    input  logic [SAMPLE_W-1:0] odd_re,
    input  logic [SAMPLE_W-1:0] odd_im,
    input  logic [TW_W-1:0]     tw_re,
    input  logic [TW_W-1:0]     tw_im,
    input  logic [TAG_W-1:0]    in_tag,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] sum_re,
    output logic [SAMPLE_W-1:0] sum_im,
    output logic [SAMPLE_W-1:0] diff_re,
    output logic [SAMPLE_W-1:0] diff_im,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_last,
    output logic                sat_flag,
    input  logic                sat_clear
);
    localparam int STAGES = 3;
    localparam int PW     = SAMPLE_W + TW_W;

    localparam logic [SAMPLE_W-1:0] SMAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] SMIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic signed [PW:0]  WMAX = {{(PW+1-SAMPLE_W){1'b0}}, SMAX};
    localparam logic signed [PW:0]  WMIN = {{(PW+2-SAMPLE_W){1'b1}}, {(SAMPLE_W-1){1'b0}}};
    localparam logic signed [PW:0]  RND  = {{(PW+3-TW_W){1'b0}}, 1'b1, {(TW_W-2){1'b0}}};

    // {clamped, value} for the wide twiddle product after rounding/shift
    function automatic logic [SAMPLE_W:0] sat_wide(input logic signed [PW:0] v);
        sat_wide = {1'b0, v[SAMPLE_W-1:0]};
        if (v > WMAX)      sat_wide = {1'b1, SMAX};
        else if (v < WMIN) sat_wide = {1'b1, SMIN};
    endfunction

    // {clamped, value} for the one-bit-grown S3 add/sub result
    function automatic logic [SAMPLE_W:0] fin(input logic signed [SAMPLE_W:0] v);
`ifdef FFT_BFLY_SCALE_EN
        fin = {1'b0, v[SAMPLE_W:1] + {{(SAMPLE_W-1){1'b0}}, v[0]}};
`else
        fin = {1'b0, v[SAMPLE_W-1:0]};
        if (v[SAMPLE_W] != v[SAMPLE_W-1]) fin = {1'b1, v[SAMPLE_W] ? SMIN : SMAX};
`endif
    endfunction

    logic                       w_adv;
    logic [STAGES:1]            r_vld_pipe;
    logic signed [PW-1:0]       r_p_rr, r_p_ii, r_p_ri, r_p_ir;
    logic [SAMPLE_W-1:0]        r_e1_re, r_e1_im, r_e2_re, r_e2_im;
    logic [SAMPLE_W-1:0]        r_t_re, r_t_im;
    logic [TAG_W-1:0]           r_tag1, r_tag2;
    logic                       r_last1, r_last2;
    logic signed [PW:0]         w_pre_re, w_pre_im, w_shr_re, w_shr_im;
    logic [SAMPLE_W:0]          w_s2_re, w_s2_im;
    logic [3:0][SAMPLE_W:0]     w_s3;
    logic                       w_sat_set;

    assign w_adv     = !r_vld_pipe[STAGES] | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_vld_pipe[STAGES];

    always_ff @(posedge clk) begin
        if (rst)        r_vld_pipe <= '0;
        else if (w_adv) r_vld_pipe <= {r_vld_pipe[STAGES-1:1], in_valid};
    end

    // S1: raw products
    always_ff @(posedge clk) begin
        if (rst) begin
            {r_p_rr, r_p_ii, r_p_ri, r_p_ir} <= '0;
            {r_e1_re, r_e1_im, r_tag1, r_last1} <= '0;
        end else if (w_adv) begin
            r_p_rr  <= $signed(odd_re) * $signed(tw_re);
            r_p_ii  <= $signed(odd_im) * $signed(tw_im);
            r_p_ri  <= $signed(odd_re) * $signed(tw_im);
            r_p_ir  <= $signed(odd_im) * $signed(tw_re);
            r_e1_re <= even_re;
            r_e1_im <= even_im;
            r_tag1  <= in_tag;
            r_last1 <= in_last;
        end
    end

    // S2: complex combine, round half-up, drop the Q1.(TW_W-1) fraction, saturate
    assign w_pre_re = {r_p_rr[PW-1], r_p_rr} - {r_p_ii[PW-1], r_p_ii} + RND;
    assign w_pre_im = {r_p_ri[PW-1], r_p_ri} + {r_p_ir[PW-1], r_p_ir} + RND;
    assign w_shr_re = w_pre_re >>> (TW_W-1);
    assign w_shr_im = w_pre_im >>> (TW_W-1);
    assign w_s2_re  = sat_wide(w_shr_re);
    assign w_s2_im  = sat_wide(w_shr_im);

    always_ff @(posedge clk) begin
        if (rst) begin
            {r_t_re, r_t_im, r_e2_re, r_e2_im, r_tag2, r_last2} <= '0;
        end else if (w_adv) begin
            r_t_re  <= w_s2_re[SAMPLE_W-1:0];
            r_t_im  <= w_s2_im[SAMPLE_W-1:0];
            r_e2_re <= r_e1_re;
            r_e2_im <= r_e1_im;
            r_tag2  <= r_tag1;
            r_last2 <= r_last1;
        end
    end

    // S3: even +/- W*odd with one bit of growth
    assign w_s3[0] = fin({r_e2_re[SAMPLE_W-1], r_e2_re} + {r_t_re[SAMPLE_W-1], r_t_re});
    assign w_s3[1] = fin({r_e2_im[SAMPLE_W-1], r_e2_im} + {r_t_im[SAMPLE_W-1], r_t_im});
    assign w_s3[2] = fin({r_e2_re[SAMPLE_W-1], r_e2_re} - {r_t_re[SAMPLE_W-1], r_t_re});
    assign w_s3[3] = fin({r_e2_im[SAMPLE_W-1], r_e2_im} - {r_t_im[SAMPLE_W-1], r_t_im});

    always_ff @(posedge clk) begin
        if (rst) begin
            {sum_re, sum_im, diff_re, diff_im, out_tag, out_last} <= '0;
        end else if (w_adv) begin
            sum_re   <= w_s3[0][SAMPLE_W-1:0];
            sum_im   <= w_s3[1][SAMPLE_W-1:0];
            diff_re  <= w_s3[2][SAMPLE_W-1:0];
            diff_im  <= w_s3[3][SAMPLE_W-1:0];
            out_tag  <= r_tag2;
            out_last <= r_last2;
        end
    end

    // bubbles never flag; only real beats moving forward can set the sticky bit
    assign w_sat_set = w_adv & ((r_vld_pipe[1] & (w_s2_re[SAMPLE_W] | w_s2_im[SAMPLE_W])) |
                                (r_vld_pipe[2] & (w_s3[0][SAMPLE_W] | w_s3[1][SAMPLE_W] |
                                                  w_s3[2][SAMPLE_W] | w_s3[3][SAMPLE_W])));

    always_ff @(posedge clk) begin
        if (rst)            sat_flag <= 1'b0;
        else if (sat_clear) sat_flag <= 1'b0;
        else if (w_sat_set) sat_flag <= 1'b1;
    end
endmodule

// File: tb/tb_fft_butterfly_stream.sv
// Self-checking bench for fft_butterfly_stream (SAMPLE_W=16, TW_W=16, TAG_W=8).
// Honors FFT_BFLY_SCALE_EN in its reference model.
module tb_fft_butterfly_stream;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_last, out_valid, out_ready, out_last;
    logic        sat_flag, sat_clear;
    logic [15:0] even_re, even_im, odd_re, odd_im, tw_re, tw_im;
    logic [15:0] sum_re, sum_im, diff_re, diff_im;
    logic [7:0]  in_tag, out_tag;

    int checks = 0;
    int errors = 0;

    logic [63:0] c_pk;
    logic [7:0]  c_tag;
    logic        c_last, c_ovld, c_ird, c_sat;

    always #5 clk = ~clk;

    fft_butterfly_stream #(.SAMPLE_W(16), .TW_W(16), .TAG_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .even_re(even_re), .even_im(even_im), .odd_re(odd_re), .odd_im(odd_im),
        .tw_re(tw_re), .tw_im(tw_im), .in_tag(in_tag), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum_re(sum_re), .sum_im(sum_im), .diff_re(diff_re), .diff_im(diff_im),
        .out_tag(out_tag), .out_last(out_last),
        .sat_flag(sat_flag), .sat_clear(sat_clear)
    );

    // ---------------- reference model ----------------
    function automatic logic [15:0] sat16(input longint v, inout bit c);
        if (v > 32767)  begin c = 1'b1; return 16'h7fff; end
        if (v < -32768) begin c = 1'b1; return 16'h8000; end
        return 16'(v);
    endfunction

    function automatic logic [63:0] bfly(input logic [15:0] er, ei, orr, oi, tr, ti, output bit c);
        longint e_r = longint'($signed(er));
        longint e_i = longint'($signed(ei));
        longint o_r = longint'($signed(orr));
        longint o_i = longint'($signed(oi));
        longint w_r = longint'($signed(tr));
        longint w_i = longint'($signed(ti));
        longint t_r, t_i;
        c = 1'b0;
        t_r = longint'($signed(sat16((o_r * w_r - o_i * w_i + 16384) >>> 15, c)));
        t_i = longint'($signed(sat16((o_r * w_i + o_i * w_r + 16384) >>> 15, c)));
`ifdef FFT_BFLY_SCALE_EN
        return {16'((e_r + t_r + 1) >>> 1), 16'((e_i + t_i + 1) >>> 1),
                16'((e_r - t_r + 1) >>> 1), 16'((e_i - t_i + 1) >>> 1)};
`else
        return {sat16(e_r + t_r, c), sat16(e_i + t_i, c), sat16(e_r - t_r, c), sat16(e_i - t_i, c)};
`endif
    endfunction

    function automatic logic [63:0] pk(input int a, input int b, input int d, input int e);
        return {16'(a), 16'(b), 16'(d), 16'(e)};
    endfunction

    function automatic logic [15:0] rs();
        case ($urandom_range(0, 7))
            0:       return 16'h7fff;
            1:       return 16'h8000;
            2:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    // ---------------- drive / sample ----------------
    task automatic set_in(input bit v, input logic [15:0] er, ei, orr, oi, tr, ti,
                          input logic [7:0] tg, input bit lst);
        in_valid = v; even_re = er; even_im = ei; odd_re = orr; odd_im = oi;
        tw_re = tr; tw_im = ti; in_tag = tg; in_last = lst;
    endtask

    // called just after a negedge with inputs already driven; reports the
    // transfers the coming posedge will perform, then waits for the next negedge
    task automatic tick(output bit acc, output bit dlv);
        #1;
        acc    = in_valid && in_ready;
        dlv    = out_valid && out_ready;
        c_pk   = {sum_re, sum_im, diff_re, diff_im};
        c_tag  = out_tag;
        c_last = out_last;
        c_ovld = out_valid;
        c_ird  = in_ready;
        c_sat  = sat_flag;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b1; out_ready = 1'b0; sat_clear = 1'b0;
        set_in(1'b1, 16'h1234, 16'h5678, 16'h7fff, 16'h8000, 16'h7fff, 16'h8000, 8'hff, 1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        set_in(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag got %0b exp 0", sat_flag); end
        checks++; if ({sum_re, sum_im, diff_re, diff_im, out_tag, out_last} !== 73'd0) begin
            errors++; $display("FAIL reset_out_data got %h/%h/%0b exp 0", {sum_re, sum_im, diff_re, diff_im}, out_tag, out_last);
        end
        @(negedge clk);
    endtask

    // single beat in, wait for it, compare against fixed expectations
    task automatic run_single(input string nm, input logic [15:0] er, ei, orr, oi, tr, ti,
                              input logic [63:0] exp_pk, input bit exp_sat);
        bit acc, dlv;
        int n;
        out_ready = 1'b1;
        set_in(1'b1, er, ei, orr, oi, tr, ti, 8'h5a, 1'b1);
        tick(acc, dlv);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL %s_accept got %0b exp 1", nm, acc); end
        set_in(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0);
        n = 0; dlv = 1'b0;
        while (!dlv && n < 10) begin tick(acc, dlv); n++; end
        checks++; if (n !== 3 || !dlv) begin errors++; $display("FAIL %s_latency got %0d exp 3", nm, n); end
        checks++; if (c_pk !== exp_pk) begin errors++; $display("FAIL %s_data got %h exp %h", nm, c_pk, exp_pk); end
        checks++; if ({c_tag, c_last} !== {8'h5a, 1'b1}) begin errors++; $display("FAIL %s_side got %h/%0b exp 5a/1", nm, c_tag, c_last); end
        checks++; if (c_sat !== exp_sat) begin errors++; $display("FAIL %s_sat got %0b exp %0b", nm, c_sat, exp_sat); end
    endtask

    task automatic test_basic;
`ifdef FFT_BFLY_SCALE_EN
        run_single("basic", 16'd1000, 16'd0, 16'd2000, 16'd0, 16'h4000, 16'h0000, pk(1000, 0, 0, 0), 1'b0);
`else
        run_single("basic", 16'd1000, 16'd0, 16'd2000, 16'd0, 16'h4000, 16'h0000, pk(2000, 0, 0, 0), 1'b0);
`endif
    endtask

    task automatic test_rounding;
`ifdef FFT_BFLY_SCALE_EN
        run_single("round", 16'd0, 16'd0, 16'd100, 16'd200, 16'h0000, 16'h8000, pk(100, -50, -100, 50), 1'b0);
`else
        run_single("round", 16'd0, 16'd0, 16'd100, 16'd200, 16'h0000, 16'h8000, pk(200, -100, -200, 100), 1'b0);
`endif
    endtask

    task automatic test_saturation;
        bit acc, dlv;
`ifdef FFT_BFLY_SCALE_EN
        run_single("sat", 16'd32000, 16'd0, 16'd32000, 16'd0, 16'h4000, 16'h0000, pk(24000, 0, 8000, 0), 1'b0);
`else
        run_single("sat", 16'd32000, 16'd0, 16'd32000, 16'd0, 16'h4000, 16'h0000, pk(32767, 0, 16000, 0), 1'b1);
`endif
        sat_clear = 1'b1;
        tick(acc, dlv);
        sat_clear = 1'b0;
        #1;
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_clear got %0b exp 0", sat_flag); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        bit acc, dlv;
        int sent, t;
        logic [7:0] got_tag[$];
        bit         got_last[$];
        sent = 0;
        for (t = 0; t < 40 && got_tag.size() < 8; t++) begin
            out_ready = !(t >= 4 && t <= 6);
            set_in(sent < 8, rs(), rs(), rs(), rs(), rs(), rs(), 8'(sent), sent == 7);
            tick(acc, dlv);
            if (t >= 4 && t <= 6) begin
                checks++; if (c_ird !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %0b exp 0", t, c_ird); end
            end
            if (acc) sent++;
            if (dlv) begin got_tag.push_back(c_tag); got_last.push_back(c_last); end
        end
        set_in(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0);
        out_ready = 1'b1;
        repeat (5) begin
            tick(acc, dlv);
            if (dlv) begin got_tag.push_back(c_tag); got_last.push_back(c_last); end
        end
        checks++; if (sent !== 8) begin errors++; $display("FAIL bp_sent got %0d exp 8", sent); end
        checks++; if (got_tag.size() !== 8) begin errors++; $display("FAIL bp_count got %0d exp 8", got_tag.size()); end
        for (int i = 0; i < got_tag.size() && i < 8; i++) begin
            checks++;
            if ({got_tag[i], got_last[i]} !== {8'(i), i == 7}) begin
                errors++; $display("FAIL bp_order idx %0d got %0d/%0b exp %0d/%0b", i, got_tag[i], got_last[i], i, i == 7);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit acc, dlv;
        int late;
        out_ready = 1'b1;
        set_in(1'b1, 16'd32000, 16'd0, 16'd32000, 16'd0, 16'h4000, 16'h0000, 8'd1, 1'b0);
        tick(acc, dlv);
        set_in(1'b1, rs(), rs(), rs(), rs(), rs(), rs(), 8'd2, 1'b0);
        tick(acc, dlv);
        set_in(1'b1, rs(), rs(), rs(), rs(), rs(), rs(), 8'd3, 1'b1);
        tick(acc, dlv);
        set_in(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0);
        rst = 1'b1;
        tick(acc, dlv);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %0b exp 0", out_valid); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL rstmid_sat got %0b exp 0", sat_flag); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %0b exp 1", in_ready); end
        @(negedge clk);
        late = 0;
        repeat (8) begin tick(acc, dlv); if (dlv) late++; end
        checks++; if (late !== 0) begin errors++; $display("FAIL rstmid_stale got %0d beats exp 0", late); end
    endtask

    task automatic test_random;
        bit acc, dlv, cl, sticky, stall;
        int sent, rcvd, cyc;
        logic [72:0] q[$];
        logic [72:0] exp_v, prev;
        sent = 0; rcvd = 0; cyc = 0; sticky = 1'b0; stall = 1'b0; prev = '0;
        sat_clear = 1'b1; set_in(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0);
        tick(acc, dlv);
        sat_clear = 1'b0;
        while ((sent < 10000 || q.size() != 0) && cyc < 60000) begin
            out_ready = (sent >= 10000) || ($urandom_range(0, 3) != 0);
            set_in((sent < 10000) && ($urandom_range(0, 3) != 0),
                   rs(), rs(), rs(), rs(), rs(), rs(), 8'($urandom), $urandom_range(0, 7) == 0);
            tick(acc, dlv);
            cyc++;
            if (stall) begin
                checks++;
                if ({c_pk, c_tag, c_last} !== prev) begin
                    errors++; $display("FAIL rand_hold cyc %0d got %h exp %h", cyc, {c_pk, c_tag, c_last}, prev);
                end
            end
            stall = c_ovld && !out_ready;
            prev  = {c_pk, c_tag, c_last};
            if (acc) begin
                q.push_back({bfly(even_re, even_im, odd_re, odd_im, tw_re, tw_im, cl), in_tag, in_last});
                sticky |= cl;
                sent++;
            end
            if (dlv) begin
                rcvd++;
                exp_v = (q.size() != 0) ? q.pop_front() : 73'hx;
                checks++;
                if ({c_pk, c_tag, c_last} !== exp_v) begin
                    errors++; $display("FAIL rand_beat %0d got %h exp %h", rcvd, {c_pk, c_tag, c_last}, exp_v);
                end
            end
        end
        checks++; if (sent !== rcvd || q.size() != 0) begin
            errors++; $display("FAIL rand_count delivered %0d exp %0d (pending %0d)", rcvd, sent, q.size());
        end
        checks++; if (c_sat !== sticky) begin errors++; $display("FAIL rand_sat got %0b exp %0b", c_sat, sticky); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
